// File: rtl/frame_config_loader.sv
// Column bitstream frame loader: hunts for the sync word, decodes frame
// headers, gathers one word per row, then strobes the addressed frame line.
module frame_config_loader #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 4,
    parameter int StrobeCycles    = 2
) (
    input  logic                                UserCLK,
    input  logic                                resetn,
    input  logic [31:0]                         in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [FrameBitsPerRow*NumRows-1:0]  FrameData,
    output logic [MaxFramesPerCol-1:0]          FrameStrobe,
    output logic                                busy,
    output logic                                cfg_done,
    output logic                                cfg_err,
    output logic [15:0]                         frames_loaded
);

    localparam logic [31:0]     SYNC       = 32'hFAB0_FAB1;
    localparam int              RowW       = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int              IdxW       = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam logic [RowW-1:0] LastRow    = RowW'(NumRows - 1);
    localparam logic [3:0]      LastStrobe = 4'(StrobeCycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        STROBE,
        GAP
    } state_t;

    state_t          state;
    logic [RowW-1:0] row_cnt;
    logic [3:0]      strobe_cnt;
    logic [IdxW-1:0] frame_idx;
    logic            take;
    logic            hdr_in_range;

    // Handshake and header range decode.
    always_comb begin
        take         = in_valid & in_ready;
        hdr_in_range = ({24'b0, in_data[7:0]} < 32'(MaxFramesPerCol));
    end

    // Loader state machine; every output is a register updated here.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            FrameData     <= '0;
            FrameStrobe   <= '0;
            busy          <= 1'b0;
            cfg_done      <= 1'b0;
            cfg_err       <= 1'b0;
            frames_loaded <= '0;
            row_cnt       <= '0;
            strobe_cnt    <= '0;
            frame_idx     <= '0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (take && in_data == SYNC) begin
                        cfg_err       <= 1'b0;
                        frames_loaded <= '0;
                        busy          <= 1'b1;
                        state         <= HDR;
                    end
                end
                HDR: begin
                    if (take) begin
                        // SYNC has bit31 set, so it must be caught before the
                        // desync test; it decodes as the out-of-range idx 0xB1.
                        if (in_data == SYNC) begin
                            cfg_err <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else if (in_data[31]) begin
                            cfg_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else if (hdr_in_range) begin
                            frame_idx <= in_data[IdxW-1:0];
                            row_cnt   <= '0;
                            state     <= DATA;
                        end else begin
                            cfg_err <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (take) begin
                        FrameData[row_cnt*FrameBitsPerRow +: FrameBitsPerRow] <= in_data;
                        if (row_cnt == LastRow) begin
                            in_ready    <= 1'b0;
                            FrameStrobe <= MaxFramesPerCol'(1) << frame_idx;
                            strobe_cnt  <= '0;
                            state       <= STROBE;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                STROBE: begin
                    if (strobe_cnt == LastStrobe) begin
                        FrameStrobe <= '0;
                        if (frames_loaded != '1) begin
                            frames_loaded <= frames_loaded + 1'b1;
                        end
                        state <= GAP;
                    end else begin
                        strobe_cnt <= strobe_cnt + 1'b1;
                    end
                end
                GAP: begin
                    in_ready <= 1'b1;
                    state    <= HDR;
                end
                default: begin
                    FrameStrobe <= '0;
                    in_ready    <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_config_loader.md
Name: frame_config_loader

Overview:
- Bitstream frame loader for one fabric column; sits directly upstream of the tile config ports and drives the per-row FrameData buses and the column FrameStrobe vector.
- Accepts 32-bit configuration words over a valid/ready stream, detects a sync word and decodes frame headers.
- Gathers one data word per row, then pulses the addressed FrameStrobe line so the tile config latches capture the frame.

Parameters:
- MaxFramesPerCol, 20, width of FrameStrobe; number of frames per column.
- FrameBitsPerRow, 32, width of one row's FrameData slice; equals the input word width.
- NumRows, 4, number of tile rows in the column; data words per frame.
- StrobeCycles, 2, cycles FrameStrobe is held high per frame (1..15).

Ports:
- UserCLK input 1: clock; all state updates on the rising edge.
- resetn input 1: asynchronous active-low reset.
- in_data input 32: configuration word.
- in_valid input 1: in_data is valid.
- in_ready output 1: loader accepts a word this cycle.
- FrameData output FrameBitsPerRow*NumRows: row r occupies bits [r*32+31 : r*32].
- FrameStrobe output MaxFramesPerCol: one-hot write strobe, or all zero.
- busy output 1: high in every state except IDLE.
- cfg_done output 1: one-cycle pulse on a desync header.
- cfg_err output 1: sticky error flag.
- frames_loaded output 16: count of frames strobed since the last sync; saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - in_ready=0 while resetn=0 and 1 from the first edge after release.
  - FrameData=0, FrameStrobe=0, busy=0, cfg_done=0, cfg_err=0, frames_loaded=0, state=IDLE.
  - Reset asserted mid-operation clears FrameStrobe immediately, without waiting for a clock edge.
- Transfer rule: a word is taken on a rising edge with in_valid=1 and in_ready=1. in_data is ignored otherwise.
- All outputs are registered.
- States:
  - IDLE (in_ready=1):
    - Words other than SYNC=32'hFAB0_FAB1 are discarded.
    - On SYNC: cfg_err<=0, frames_loaded<=0, go to HDR.
  - HDR (in_ready=1), header word fields:
    - bit31=1: desync. cfg_done pulses the following cycle; go to IDLE.
    - bit31=0 and bits[7:0] < MaxFramesPerCol: latch frame_idx=bits[7:0], row counter<=0, go to DATA.
    - bit31=0 and bits[7:0] >= MaxFramesPerCol: cfg_err<=1, go to IDLE. No strobe is issued.
    - A SYNC word received in HDR is treated as a header with idx 0xB1, which is out of range, so it raises the error.
  - DATA (in_ready=1):
    - The k-th accepted word (k=0..NumRows-1) is written to FrameData row k on the accepting edge. Other rows keep their value.
    - After the word for row NumRows-1, go to STROBE.
  - STROBE (in_ready=0):
    - FrameStrobe[frame_idx]=1 for exactly StrobeCycles cycles, starting the cycle after the last data word is accepted.
    - FrameData is stable for the whole window.
    - frames_loaded increments once at strobe end (saturating), then go to GAP.
  - GAP (in_ready=0): one cycle with FrameStrobe=0, then go to HDR.
- Latency:
  - Last data word accepted at edge T → FrameStrobe high over edges T+1..T+StrobeCycles.
  - in_ready returns high at edge T+StrobeCycles+2.
- FrameData keeps its last value after the strobe and in IDLE; it is cleared only by reset.
- in_valid held low in any state means a stall with no state change. There is no timeout.
- Counters:
  - Row counter is clog2(NumRows) bits.
  - Strobe counter is 4 bits.
  - Neither counter wraps within a frame.
- FrameStrobe never has more than one bit set.

Test Plan:
- Reset, then SYNC, header 0x00000005, data 0x11111111 / 0x22222222 / 0x33333333 / 0x44444444 → FrameData=0x44444444_33333333_22222222_11111111; FrameStrobe=0x00020 for exactly 2 cycles; frames_loaded=1; in_ready low for 3 cycles.
- Junk 0xDEADBEEF before SYNC → discarded; busy stays 0; no FrameData change.
- SYNC, header 0x00000014 (idx 20) → cfg_err=1, state IDLE, FrameStrobe stays 0. A new SYNC clears cfg_err.
- SYNC, two frames (idx 0 and idx 19), then header 0x80000000 → strobes 0x00001 then 0x80000; frames_loaded=2; cfg_done pulses 1 cycle; busy=0.
- in_valid toggled 1/0 every cycle during DATA → exactly 4 words captured in order; strobe begins one cycle after the 4th accepted word.
- resetn pulled low during the first STROBE cycle → FrameStrobe=0 before the next clock edge; all outputs at reset values.
